// File: rtl/ucsbece154b_icache_pkg.sv
// Shared types for the two-way instruction cache: FSM state encoding and word width.
package ucsbece154b_icache_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMemReq = 2'd1,
    StRefill = 2'd2
  } state_t;

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// One way of the instruction cache: valid bits, tags and data words for every set.
module ucsbece154b_icache_way
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_SETS),
  parameter int unsigned OFF_W       = $clog2(BLOCK_WORDS),
  parameter int unsigned TAG_W       = 32 - 2 - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset_ni,
  // read port
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [OFF_W-1:0]  rd_offset,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              valid_o,
  output logic              hit_o,
  output logic [WORD_W-1:0] word_o,
  // write port
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_beat,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              word_we,
  input  logic              commit,
  input  logic [TAG_W-1:0]  commit_tag
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [WORD_W-1:0]   data_q [NUM_SETS][BLOCK_WORDS];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= '0;
    end else if (commit) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags and data are deliberately not reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (word_we) data_q[wr_index][wr_beat] <= wr_data;
    if (commit) tag_q[wr_index] <= commit_tag;
  end

  assign valid_o = valid_q[rd_index];
  assign hit_o   = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign word_o  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Two-way set-associative read-only instruction cache with combinational hit path and
// beat-wise block refill.
module ucsbece154b_icache
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              ReadEnable_i,
  input  logic [31:0]       ReadAddress_i,
  output logic [31:0]       Instruction_o,
  output logic              Ready_o,
  output logic              Busy_o,
  output logic [31:0]       MemReadAddress_o,
  output logic              MemReadRequest_o,
  input  logic [31:0]       MemDataIn_i,
  input  logic              MemDataReady_i
);

  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam int unsigned BLK_W = 32 - 2 - OFF_W;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;

  assign offset = ReadAddress_i[OFF_W+1:2];
  assign index  = ReadAddress_i[OFF_W+2 +: IDX_W];
  assign tag    = ReadAddress_i[31 -: TAG_W];

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic                victim_q, victim_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic [IDX_W-1:0] blk_index;
  logic [TAG_W-1:0] blk_tag;
  assign blk_index = blk_q[IDX_W-1:0];
  assign blk_tag   = blk_q[BLK_W-1 -: TAG_W];

  logic [1:0]  way_hit;
  logic [1:0]  way_valid;
  logic [31:0] way_word [2];
  logic        beat_we;
  logic        last_beat;
  logic        commit;

  assign beat_we   = (state_q == StRefill) && MemDataReady_i;
  assign last_beat = (beat_q == OFF_W'(BLOCK_WORDS - 1));
  assign commit    = beat_we && last_beat;

  ucsbece154b_icache_way #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_way0 (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .rd_index   (index),
    .rd_offset  (offset),
    .rd_tag     (tag),
    .valid_o    (way_valid[0]),
    .hit_o      (way_hit[0]),
    .word_o     (way_word[0]),
    .wr_index   (blk_index),
    .wr_beat    (beat_q),
    .wr_data    (MemDataIn_i),
    .word_we    (beat_we && !victim_q),
    .commit     (commit && !victim_q),
    .commit_tag (blk_tag)
  );

  ucsbece154b_icache_way #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_way1 (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .rd_index   (index),
    .rd_offset  (offset),
    .rd_tag     (tag),
    .valid_o    (way_valid[1]),
    .hit_o      (way_hit[1]),
    .word_o     (way_word[1]),
    .wr_index   (blk_index),
    .wr_beat    (beat_q),
    .wr_data    (MemDataIn_i),
    .word_we    (beat_we && victim_q),
    .commit     (commit && victim_q),
    .commit_tag (blk_tag)
  );

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    blk_d            = blk_q;
    victim_d         = victim_q;
    lru_d            = lru_q;
    Ready_o          = 1'b0;
    MemReadRequest_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ReadEnable_i) begin
          if (|way_hit) begin
            Ready_o      = 1'b1;
            // LRU names the way to evict next, i.e. the one not just used.
            lru_d[index] = way_hit[0];
          end else begin
            blk_d    = ReadAddress_i[31 -: BLK_W];
            victim_d = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[index]);
            state_d  = StMemReq;
          end
        end
      end
      StMemReq: begin
        MemReadRequest_o = 1'b1;
        state_d          = StRefill;
      end
      StRefill: begin
        if (MemDataReady_i) begin
          if (last_beat) begin
            beat_d           = '0;
            lru_d[blk_index] = ~victim_q;
            state_d          = StIdle;
          end else begin
            beat_d = beat_q + OFF_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      blk_q    <= '0;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      blk_q    <= blk_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
    end
  end

  assign Busy_o           = (state_q != StIdle);
  assign MemReadAddress_o = {blk_q, {(OFF_W + 2){1'b0}}};
  assign Instruction_o    = way_hit[1] ? way_word[1] : way_word[0];

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Self-checking bench: block-address level cache model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ucsbece154b_icache;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        ReadEnable_i;
  logic [31:0] ReadAddress_i;
  logic [31:0] Instruction_o;
  logic        Ready_o;
  logic        Busy_o;
  logic [31:0] MemReadAddress_o;
  logic        MemReadRequest_o;
  logic [31:0] MemDataIn_i;
  logic        MemDataReady_i;

  ucsbece154b_icache dut (
    .clk              (clk),
    .reset_ni         (reset_ni),
    .ReadEnable_i     (ReadEnable_i),
    .ReadAddress_i    (ReadAddress_i),
    .Instruction_o    (Instruction_o),
    .Ready_o          (Ready_o),
    .Busy_o           (Busy_o),
    .MemReadAddress_o (MemReadAddress_o),
    .MemReadRequest_o (MemReadRequest_o),
    .MemDataIn_i      (MemDataIn_i),
    .MemDataReady_i   (MemDataReady_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int req_count = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each way/set remembers the block address it holds plus its words.
  bit          m_valid [2][8];
  logic [31:0] m_blk   [2][8];
  logic [31:0] m_data  [2][8][4];
  int          m_lru   [8];
  bit          m_busy, m_req;
  logic [31:0] m_addr;
  int          m_victim, m_beats;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) % 8);
  endfunction

  function automatic int mhit(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][set_of(a)] && m_blk[w][set_of(a)] == (a & ~32'hF)) return w;
    return -1;
  endfunction

  function automatic int mvictim(input logic [31:0] a);
    if (!m_valid[0][set_of(a)]) return 0;
    if (!m_valid[1][set_of(a)]) return 1;
    return m_lru[set_of(a)];
  endfunction

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < 8; s++) begin
        m_valid[0][s] <= 1'b0;
        m_valid[1][s] <= 1'b0;
        m_lru[s]      <= 0;
      end
      m_busy  <= 1'b0;
      m_req   <= 1'b0;
      m_beats <= 0;
    end else if (!m_busy) begin
      if (ReadEnable_i) begin
        if (mhit(ReadAddress_i) >= 0) begin
          m_lru[set_of(ReadAddress_i)] <= 1 - mhit(ReadAddress_i);
        end else begin
          m_busy   <= 1'b1;
          m_req    <= 1'b1;
          m_addr   <= ReadAddress_i & ~32'hF;
          m_victim <= mvictim(ReadAddress_i);
        end
      end
    end else if (m_req) begin
      m_req <= 1'b0;
    end else if (MemDataReady_i) begin
      m_data[m_victim][set_of(m_addr)][m_beats] <= MemDataIn_i;
      if (m_beats == 3) begin
        m_valid[m_victim][set_of(m_addr)] <= 1'b1;
        m_blk[m_victim][set_of(m_addr)]   <= m_addr;
        m_lru[set_of(m_addr)]             <= 1 - m_victim;
        m_busy                            <= 1'b0;
        m_beats                           <= 0;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  int  w_now;
  bit  exp_ready;
  always @(negedge clk) begin
    if (run) begin
      w_now     = mhit(ReadAddress_i);
      exp_ready = reset_ni && !m_busy && ReadEnable_i && (w_now >= 0);
      chk("ready", {31'b0, Ready_o}, {31'b0, exp_ready});
      chk("busy", {31'b0, Busy_o}, {31'b0, m_busy});
      chk("memreq", {31'b0, MemReadRequest_o}, {31'b0, m_req});
      if (m_busy) chk("memaddr", MemReadAddress_o, m_addr);
      if (exp_ready) chk("instr", Instruction_o, m_data[w_now][set_of(ReadAddress_i)][ReadAddress_i[3:2]]);
    end
  end

  always @(posedge clk) if (MemReadRequest_o) req_count <= req_count + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    MemDataReady_i = 1'b1;
    MemDataIn_i    = d;
    step();
    MemDataReady_i = 1'b0;
  endtask

  // Waits (bounded) for the request pulse, then delivers four beats d0..d0+3.
  task automatic do_refill(input logic [31:0] d0, input int gap);
    int n = 0;
    while (!MemReadRequest_o && n < 20) begin
      step();
      n++;
    end
    chk("refill_req_seen", {31'b0, MemReadRequest_o}, 32'd1);
    if (!MemReadRequest_o) return;
    step();
    for (int b = 0; b < 4; b++) begin
      repeat (gap) step();
      beat(d0 + b);
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    step();
    step();
    reset_ni = 1'b1;
  endtask

  int rc0;

  initial begin
    reset_ni       = 1'b0;
    ReadEnable_i   = 1'b0;
    ReadAddress_i  = 32'h0;
    MemDataIn_i    = 32'h0;
    MemDataReady_i = 1'b0;
    step();
    run = 1'b1;
    do_reset();
    chk("reset_ready", {31'b0, Ready_o}, 32'd0);
    chk("reset_busy", {31'b0, Busy_o}, 32'd0);

    // 1: cold miss
    rc0 = req_count;
    ReadEnable_i  = 1'b1;
    ReadAddress_i = 32'h10;
    #1 chk("t1_miss", {31'b0, Ready_o}, 32'd0);
    step();
    chk("t1_reqaddr", MemReadAddress_o, 32'h10);
    do_refill(32'hA0, 0);
    chk("t1_ready", {31'b0, Ready_o}, 32'd1);
    chk("t1_word0", Instruction_o, 32'hA0);
    chk("t1_reqs", req_count - rc0, 32'd1);
    ReadAddress_i = 32'h1C;
    #1 chk("t1_word3", Instruction_o, 32'hA3);
    step();

    // 2: LRU eviction in set 1
    ReadAddress_i = 32'h90;
    step();
    do_refill(32'hB0, 0);
    chk("t2_90_word0", Instruction_o, 32'hB0);
    ReadAddress_i = 32'h14;
    step();
    ReadAddress_i = 32'h110;
    step();
    chk("t2_110_reqaddr", MemReadAddress_o, 32'h110);
    do_refill(32'hC0, 0);
    chk("t2_110_word0", Instruction_o, 32'hC0);
    ReadAddress_i = 32'h18;
    #1 chk("t2_10_hit", {31'b0, Ready_o}, 32'd1);
    chk("t2_10_word2", Instruction_o, 32'hA2);
    step();
    ReadAddress_i = 32'h90;
    #1 chk("t2_90_evicted", {31'b0, Ready_o}, 32'd0);
    step();
    do_refill(32'hB0, 0);

    // 3: gapped beats
    rc0 = req_count;
    ReadAddress_i = 32'h20;
    step();
    do_refill(32'hD0, 3);
    chk("t3_reqs", req_count - rc0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ReadAddress_i = 32'h20 + 32'(4 * i);
      #1 chk("t3_word", Instruction_o, 32'hD0 + 32'(i));
    end
    step();

    // 4: reset mid-refill
    ReadAddress_i = 32'h50;
    step();
    step();
    beat(32'hE0);
    beat(32'hE1);
    reset_ni = 1'b0;
    #1;
    chk("t4_busy", {31'b0, Busy_o}, 32'd0);
    chk("t4_req", {31'b0, MemReadRequest_o}, 32'd0);
    chk("t4_ready", {31'b0, Ready_o}, 32'd0);
    step();
    reset_ni = 1'b1;
    ReadAddress_i = 32'h10;
    #1 chk("t4_10_miss", {31'b0, Ready_o}, 32'd0);
    step();
    do_refill(32'hF0, 1);
    chk("t4_10_word0", Instruction_o, 32'hF0);

    // 5: address change during refill
    do_reset();
    ReadAddress_i = 32'h10;
    step();
    step();
    beat(32'h30);
    ReadAddress_i = 32'h40;
    beat(32'h31);
    beat(32'h32);
    beat(32'h33);
    chk("t5_40_miss", {31'b0, Ready_o}, 32'd0);
    step();
    chk("t5_40_reqaddr", MemReadAddress_o, 32'h40);
    do_refill(32'h70, 0);
    ReadAddress_i = 32'h14;
    #1 chk("t5_10_hit", {31'b0, Ready_o}, 32'd1);
    chk("t5_10_word1", Instruction_o, 32'h31);
    step();

    // 6: disabled
    rc0 = req_count;
    ReadEnable_i  = 1'b0;
    ReadAddress_i = 32'h200;
    repeat (5) begin
      #1 chk("t6_ready", {31'b0, Ready_o}, 32'd0);
      step();
    end
    chk("t6_busy", {31'b0, Busy_o}, 32'd0);
    chk("t6_reqs", req_count - rc0, 32'd0);

    step();
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
